// File: rtl/mips_branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters for the IF stage.
// Define BP_STATS_EN to add lookup/update/mispredict statistics counters.
module mips_branch_predictor #(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned CNT_W   = 2,
   parameter int unsigned TAG_W   = 32 - 2 - $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic [31:0] if_pc_i,
   output logic        pred_taken_o,
   output logic [31:0] pred_target_o,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic        upd_taken_i,
   input  logic [31:0] upd_target_i,
   input  logic        upd_pred_taken_i,
   input  logic [31:0] upd_pred_target_i,
   output logic        mispredict_o,
   output logic [31:0] correct_pc_o
`ifdef BP_STATS_EN
   ,
   input  logic        stat_clr_i,
   output logic [31:0] stat_lookups_o,
   output logic [31:0] stat_updates_o,
   output logic [31:0] stat_mispred_o
`endif
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
   localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [29:0]        target_q [ENTRIES];
   logic [29:0]        target_d [ENTRIES];
   logic [CNT_W-1:0]   cnt_q    [ENTRIES];
   logic [CNT_W-1:0]   cnt_d    [ENTRIES];

   logic [IDX_W-1:0] if_idx_c, upd_idx_c;
   logic [TAG_W-1:0] if_tag_c, upd_tag_c;
   logic             if_hit_c, upd_hit_c, upd_en_c;

   assign if_idx_c  = if_pc_i[IDX_W+1:2];
   assign if_tag_c  = if_pc_i[31:IDX_W+2];
   assign upd_idx_c = upd_pc_i[IDX_W+1:2];
   assign upd_tag_c = upd_pc_i[31:IDX_W+2];
   assign if_hit_c  = valid_q[if_idx_c] && (tag_q[if_idx_c] == if_tag_c);
   assign upd_hit_c = valid_q[upd_idx_c] && (tag_q[upd_idx_c] == upd_tag_c);
   assign upd_en_c  = upd_valid_i && !stall_i;

   // Lookup reads the registered table, so a same-cycle update is seen only next cycle
   assign pred_taken_o  = if_hit_c && cnt_q[if_idx_c][CNT_W-1];
   assign pred_target_o = pred_taken_o ? {target_q[if_idx_c], 2'b00} : if_pc_i + 32'd4;

   assign mispredict_o = upd_valid_i &&
                         ((upd_taken_i != upd_pred_taken_i) ||
                          (upd_taken_i && upd_pred_taken_i && (upd_target_i != upd_pred_target_i)));
   assign correct_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 32'd4;

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      if (upd_en_c) begin
         if (upd_hit_c) begin
            if (upd_taken_i) begin
               target_d[upd_idx_c] = upd_target_i[31:2];
               if (cnt_q[upd_idx_c] != CNT_MAX) cnt_d[upd_idx_c] = cnt_q[upd_idx_c] + CNT_W'(1);
            end else if (cnt_q[upd_idx_c] != '0) begin
               cnt_d[upd_idx_c] = cnt_q[upd_idx_c] - CNT_W'(1);
            end
         end else if (upd_taken_i) begin
            // Taken miss replaces whatever aliases at this index
            valid_d[upd_idx_c]  = 1'b1;
            tag_d[upd_idx_c]    = upd_tag_c;
            target_d[upd_idx_c] = upd_target_i[31:2];
            cnt_d[upd_idx_c]    = CNT_WT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= '0;
         tag_q    <= '{default: '0};
         target_q <= '{default: '0};
         cnt_q    <= '{default: CNT_WNT};
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] stat_lookups_q, stat_lookups_d;
   logic [31:0] stat_updates_q, stat_updates_d;
   logic [31:0] stat_mispred_q, stat_mispred_d;

   // Clear wins over increment; all counters wrap naturally
   always_comb begin
      stat_lookups_d = stat_lookups_q;
      stat_updates_d = stat_updates_q;
      stat_mispred_d = stat_mispred_q;
      if (stat_clr_i) begin
         stat_lookups_d = '0;
         stat_updates_d = '0;
         stat_mispred_d = '0;
      end else begin
         if (!stall_i)                 stat_lookups_d = stat_lookups_q + 32'd1;
         if (upd_en_c)                 stat_updates_d = stat_updates_q + 32'd1;
         if (mispredict_o && !stall_i) stat_mispred_d = stat_mispred_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_lookups_q <= '0;
         stat_updates_q <= '0;
         stat_mispred_q <= '0;
      end else begin
         stat_lookups_q <= stat_lookups_d;
         stat_updates_q <= stat_updates_d;
         stat_mispred_q <= stat_mispred_d;
      end
   end

   assign stat_lookups_o = stat_lookups_q;
   assign stat_updates_o = stat_updates_q;
   assign stat_mispred_o = stat_mispred_q;
`endif

endmodule

// File: tb/tb_mips_branch_predictor.sv
// Directed bench for mips_branch_predictor: table-driven vectors plus reset and 1-bit-counter sequences.
module tb_mips_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic [31:0] if_pc;
   logic        upd_valid, upd_taken, upd_pred_taken;
   logic [31:0] upd_pc, upd_target, upd_pred_target;
   logic        pred_taken, mispredict;
   logic [31:0] pred_target, correct_pc;
   logic        p1_taken, mis1;
   logic [31:0] p1_target, cor1;
`ifdef BP_STATS_EN
   logic        stat_clr;
   logic [31:0] s_lk, s_up, s_mp, s1_lk, s1_up, s1_mp;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mips_branch_predictor dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall), .if_pc_i(if_pc),
      .pred_taken_o(pred_taken), .pred_target_o(pred_target),
      .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
      .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
      .upd_pred_target_i(upd_pred_target),
      .mispredict_o(mispredict), .correct_pc_o(correct_pc)
`ifdef BP_STATS_EN
      , .stat_clr_i(stat_clr), .stat_lookups_o(s_lk), .stat_updates_o(s_up), .stat_mispred_o(s_mp)
`endif
   );

   mips_branch_predictor #(.ENTRIES(4), .CNT_W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .stall_i(stall), .if_pc_i(if_pc),
      .pred_taken_o(p1_taken), .pred_target_o(p1_target),
      .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
      .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
      .upd_pred_target_i(upd_pred_target),
      .mispredict_o(mis1), .correct_pc_o(cor1)
`ifdef BP_STATS_EN
      , .stat_clr_i(stat_clr), .stat_lookups_o(s1_lk), .stat_updates_o(s1_up), .stat_mispred_o(s1_mp)
`endif
   );

   typedef struct {
      bit          st;
      bit          uv;
      logic [31:0] upc;
      bit          tk;
      logic [31:0] tgt;
      bit          ptk;
      logic [31:0] ptgt;
      logic [31:0] ifpc;
      bit          e_mis;
      logic [31:0] e_cor;
      bit          e_pt;
      logic [31:0] e_ptgt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit st, bit uv, logic [31:0] upc, bit tk, logic [31:0] tgt,
                               bit ptk, logic [31:0] ptgt, logic [31:0] ifpc,
                               bit em, logic [31:0] ec, bit ept, logic [31:0] eptg);
      vec_t v;
      v.st = st; v.uv = uv; v.upc = upc; v.tk = tk; v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt;
      v.ifpc = ifpc; v.e_mis = em; v.e_cor = ec; v.e_pt = ept; v.e_ptgt = eptg;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      stall = v.st; upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.tk;
      upd_target = v.tgt; upd_pred_taken = v.ptk; upd_pred_target = v.ptgt; if_pc = v.ifpc;
   endtask

   initial begin
      vec_t idle;
      rst_n = 1'b0;
`ifdef BP_STATS_EN
      stat_clr = 1'b0;
`endif
      idle = mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h4, 0, 32'h4);
      drive(idle);

      // Rows: stall, upd_valid, upd_pc, taken, target, pred_taken, pred_target, if_pc | mispredict, correct_pc, pred_taken, pred_target
      vecs.push_back(mk(0,0,32'h0 ,0,32'h0  ,0,32'h0  ,32'h40, 0,32'h4  , 0,32'h44));
      vecs.push_back(mk(0,1,32'h40,1,32'h100,0,32'h0  ,32'h40, 1,32'h100, 0,32'h44));
      vecs.push_back(mk(0,0,32'h0 ,0,32'h0  ,0,32'h0  ,32'h40, 0,32'h4  , 1,32'h100));
      vecs.push_back(mk(0,1,32'h40,1,32'h100,1,32'h100,32'h40, 0,32'h100, 1,32'h100));
      vecs.push_back(mk(0,1,32'h40,1,32'h100,1,32'h100,32'h40, 0,32'h100, 1,32'h100));
      vecs.push_back(mk(0,1,32'h40,0,32'h0  ,1,32'h100,32'h40, 1,32'h44 , 1,32'h100));
      vecs.push_back(mk(0,1,32'h40,0,32'h0  ,1,32'h100,32'h40, 1,32'h44 , 1,32'h100));
      vecs.push_back(mk(0,0,32'h0 ,0,32'h0  ,0,32'h0  ,32'h40, 0,32'h4  , 0,32'h44));
      vecs.push_back(mk(0,1,32'h40,1,32'h104,0,32'h0  ,32'h40, 1,32'h104, 0,32'h44));
      vecs.push_back(mk(0,0,32'h0 ,0,32'h0  ,0,32'h0  ,32'h40, 0,32'h4  , 1,32'h104));
      vecs.push_back(mk(0,1,32'h40,1,32'h108,1,32'h104,32'h40, 1,32'h108, 1,32'h104));
      vecs.push_back(mk(0,1,32'h80,1,32'h200,0,32'h0  ,32'h40, 1,32'h200, 1,32'h108));
      vecs.push_back(mk(0,0,32'h0 ,0,32'h0  ,0,32'h0  ,32'h40, 0,32'h4  , 0,32'h44));
      vecs.push_back(mk(0,0,32'h0 ,0,32'h0  ,0,32'h0  ,32'h80, 0,32'h4  , 1,32'h200));
      vecs.push_back(mk(0,1,32'hC0,0,32'h0  ,0,32'h0  ,32'h80, 0,32'hC4 , 1,32'h200));
      vecs.push_back(mk(0,0,32'h0 ,0,32'h0  ,0,32'h0  ,32'h80, 0,32'h4  , 1,32'h200));
      vecs.push_back(mk(0,0,32'h0 ,1,32'h300,0,32'h0  ,32'hFFFFFFFC, 0,32'h300, 0,32'h0));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(1,1,32'h80,0,32'h0,1,32'h200,32'h80, 1,32'h84, 1,32'h200));
      vecs.push_back(mk(0,1,32'h80,0,32'h0  ,1,32'h200,32'h80, 1,32'h84 , 1,32'h200));
      vecs.push_back(mk(0,0,32'h0 ,0,32'h0  ,0,32'h0  ,32'h80, 0,32'h4  , 0,32'h84));
      vecs.push_back(mk(0,1,32'h80,1,32'h200,0,32'h0  ,32'h80, 1,32'h200, 0,32'h84));
      vecs.push_back(mk(0,0,32'h0 ,0,32'h0  ,0,32'h0  ,32'h80, 0,32'h4  , 1,32'h200));

      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(vecs[i].e_mis));
         check($sformatf("v%0d correct_pc", i), correct_pc, vecs[i].e_cor);
         check($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_pt));
         check($sformatf("v%0d pred_target", i), pred_target, vecs[i].e_ptgt);
      end

      // Async reset asserted while a taken update is being presented
      @(negedge clk);
      drive(mk(0, 1, 32'h80, 1, 32'h200, 0, 32'h0, 32'h80, 1, 32'h200, 1, 32'h200));
      #1;
      check("pre_reset pred_taken", 32'(pred_taken), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("in_reset pred_taken", 32'(pred_taken), 32'd0);
      check("in_reset pred_target", pred_target, 32'h84);
      check("in_reset mispredict", 32'(mispredict), 32'd1);
      check("in_reset correct_pc", correct_pc, 32'h200);
`ifdef BP_STATS_EN
      check("in_reset stat_lookups", s_lk, 32'd0);
      check("in_reset stat_updates", s_up, 32'd0);
      check("in_reset stat_mispred", s_mp, 32'd0);
`endif
      if_pc = 32'h40;
      #1;
      check("in_reset pred_taken 0x40", 32'(pred_taken), 32'd0);
      @(posedge clk);
      #1;
      check("reset_edge pred_taken", 32'(pred_taken), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(idle);
      if_pc = 32'h80;
      #1;
      check("post_reset pred_taken", 32'(pred_taken), 32'd0);
      check("post_reset pred_target", pred_target, 32'h84);

      // One-bit counter instance: allocation sets the bit, a not-taken clears it
      @(negedge clk);
      drive(mk(0, 1, 32'h40, 1, 32'h100, 0, 32'h0, 32'h40, 1, 32'h100, 0, 32'h44));
      #1;
      check("c1 initial pred_taken", 32'(p1_taken), 32'd0);
      @(negedge clk);
      drive(mk(0, 1, 32'h40, 0, 32'h0, 1, 32'h100, 32'h40, 1, 32'h44, 1, 32'h100));
      #1;
      check("c1 alloc pred_taken", 32'(p1_taken), 32'd1);
      check("c1 alloc pred_target", p1_target, 32'h100);
      @(negedge clk);
      drive(mk(0, 1, 32'h40, 1, 32'h100, 0, 32'h0, 32'h40, 1, 32'h100, 0, 32'h44));
      #1;
      check("c1 not_taken pred_taken", 32'(p1_taken), 32'd0);
      check("c1 not_taken pred_target", p1_target, 32'h44);
      @(negedge clk);
      drive(idle);
      if_pc = 32'h40;
      #1;
      check("c1 retaken pred_taken", 32'(p1_taken), 32'd1);
      check("c1 retaken pred_target", p1_target, 32'h100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
